// File: rtl/clk_div_odd_even_cfg.sv
// Runtime-programmable 50%-duty integer clock divider, N = 2..2^WIDTH-1, odd or even.
// Latency: ratio/enable changes take effect at the next period boundary; div_err one cycle after the load.
// Backpressure: none, en/div_load are sampled every posedge. Optional tick output under CLK_DIV_TICK_EN.
module clk_div_odd_even_cfg #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_i,
    input  logic             div_load,
    output logic             clk_div,
    output logic [WIDTH-1:0] div_cur,
    output logic             div_err,
    output logic             running
`ifdef CLK_DIV_TICK_EN
    ,
    output logic             tick
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] shadow, shadow_nx;
    logic [WIDTH-1:0] div_cur_nx;
    logic             pending, pending_nx;
    logic             pos_r, pos_nx;
    logic             neg_r;
    logic             load_ok;
    logic             wrap;

    assign load_ok = div_load && (div_i >= WIDTH'(2));
    assign wrap    = (state != IDLE) && (cnt == div_cur - WIDTH'(1));
    assign running = (state != IDLE);

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        div_cur_nx = div_cur;
        shadow_nx  = shadow;
        pending_nx = pending;

        case (state)
            IDLE: begin
                if (en) begin
                    state_nx = RUN;
                    cnt_nx   = '0;
                    if (pending) begin
                        div_cur_nx = shadow;
                        pending_nx = 1'b0;
                    end
                end
            end
            RUN, STOPPING: begin
                // Only en at the wrap decides whether another period starts.
                if (wrap) begin
                    cnt_nx   = '0;
                    state_nx = en ? RUN : IDLE;
                    if (pending) begin
                        div_cur_nx = shadow;
                        pending_nx = 1'b0;
                    end
                end else begin
                    cnt_nx   = cnt + WIDTH'(1);
                    state_nx = en ? RUN : STOPPING;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // A load on the wrap cycle lands after the old shadow was consumed above.
        if (load_ok) begin
            shadow_nx  = div_i;
            pending_nx = 1'b1;
        end

        pos_nx = (state_nx != IDLE) && (cnt_nx < (div_cur_nx >> 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shadow  <= DIV_RST;
            div_cur <= DIV_RST;
            pending <= 1'b0;
            pos_r   <= 1'b0;
            div_err <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            shadow  <= shadow_nx;
            div_cur <= div_cur_nx;
            pending <= pending_nx;
            pos_r   <= pos_nx;
            div_err <= div_load && !load_ok;
        end
    end

    // Half-cycle-delayed copy of pos_r supplies the extra half period for odd ratios.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            neg_r <= 1'b0;
        end else begin
            neg_r <= pos_r;
        end
    end

    // div_cur only changes at a wrap, when neg_r is already low, so the N[0] mask cannot glitch.
    assign clk_div = pos_r | (neg_r & div_cur[0]);

`ifdef CLK_DIV_TICK_EN
    assign tick = wrap;
`endif

endmodule

// File: tb/tb_clk_div_odd_even_cfg.sv
// Bench for clk_div_odd_even_cfg: directed vector table, ratio sweep, async reset, random run vs period model.
// Build with CLK_DIV_TICK_EN defined to also check the tick output.
module tb_clk_div_odd_even_cfg;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] div_i;
    logic             div_load;
    logic             clk_div;
    logic [WIDTH-1:0] div_cur;
    logic             div_err;
    logic             running;
`ifdef CLK_DIV_TICK_EN
    logic             tick;
`endif

    clk_div_odd_even_cfg #(.WIDTH(WIDTH), .DEFAULT_DIV(9)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_i    (div_i),
        .div_load (div_load),
        .clk_div  (clk_div),
        .div_cur  (div_cur),
        .div_err  (div_err),
        .running  (running)
`ifdef CLK_DIV_TICK_EN
        ,
        .tick     (tick)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Period-level model: position within the current period and the ratio governing it.
    bit m_run;
    int m_p;
    int m_n;
    int m_sh;
    bit m_pend;
    bit m_err;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run  = 1'b0;
        m_p    = 0;
        m_n    = 9;
        m_sh   = 9;
        m_pend = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit l, input int d);
        bit boundary;
        m_err    = l && (d < 2);
        boundary = !m_run ? e : (m_p == m_n - 1);
        if (boundary) begin
            m_p = 0;
            if (m_pend) begin
                m_n    = m_sh;
                m_pend = 1'b0;
            end
            m_run = e;
        end else if (m_run) begin
            m_p++;
        end
        if (l && d >= 2) begin
            m_sh   = d;
            m_pend = 1'b1;
        end
    endtask

    // High for floor(N/2) cycles from the period start, plus half of the next cycle when N is odd.
    function automatic bit exp_hi_first();
        int h = m_n / 2;
        return m_run && ((m_p < h) || ((m_n % 2 == 1) && (m_p == h)));
    endfunction

    function automatic bit exp_hi_second();
        return m_run && (m_p < m_n / 2);
    endfunction

    task automatic do_cycle(input bit e, input bit l, input int d, output bit s1, output bit s2);
        en       = e;
        div_load = l;
        div_i    = WIDTH'(d);
        @(posedge clk);
        model_step(e, l, d);
        #1;
        s1 = clk_div;
        chk("clk_div_first_half", int'(clk_div), int'(exp_hi_first()));
        chk("running", int'(running), int'(m_run));
        chk("div_cur", int'(div_cur), m_n);
        chk("div_err", int'(div_err), int'(m_err));
`ifdef CLK_DIV_TICK_EN
        chk("tick", int'(tick), int'(m_run && (m_p == m_n - 1)));
`endif
        @(negedge clk);
        #1;
        s2 = clk_div;
        chk("clk_div_second_half", int'(clk_div), int'(exp_hi_second()));
    endtask

    typedef struct {
        bit en;
        bit ld;
        int di;
        bit run;
        int cur;
        bit err;
        bit c1;
        bit c2;
    } vec_t;

    vec_t tbl[34];

    initial begin
        bit s1, s2, e, l, found;
        int d, r;
        int sweep[4];

        //            en ld di  run cur err c1 c2
        tbl[0]  = '{1, 0, 0,  1, 9, 0, 1, 1};
        tbl[1]  = '{1, 0, 0,  1, 9, 0, 1, 1};
        tbl[2]  = '{1, 0, 0,  1, 9, 0, 1, 1};
        tbl[3]  = '{1, 0, 0,  1, 9, 0, 1, 1};
        tbl[4]  = '{1, 1, 4,  1, 9, 0, 1, 0};
        tbl[5]  = '{1, 0, 0,  1, 9, 0, 0, 0};
        tbl[6]  = '{1, 0, 0,  1, 9, 0, 0, 0};
        tbl[7]  = '{1, 0, 0,  1, 9, 0, 0, 0};
        tbl[8]  = '{1, 0, 0,  1, 9, 0, 0, 0};
        tbl[9]  = '{1, 0, 0,  1, 4, 0, 1, 1};
        tbl[10] = '{1, 0, 0,  1, 4, 0, 1, 1};
        tbl[11] = '{1, 0, 0,  1, 4, 0, 0, 0};
        tbl[12] = '{1, 1, 1,  1, 4, 1, 0, 0};
        tbl[13] = '{1, 0, 0,  1, 4, 0, 1, 1};
        tbl[14] = '{1, 1, 0,  1, 4, 1, 1, 1};
        tbl[15] = '{1, 1, 7,  1, 4, 0, 0, 0};
        tbl[16] = '{1, 0, 0,  1, 4, 0, 0, 0};
        tbl[17] = '{1, 0, 0,  1, 7, 0, 1, 1};
        tbl[18] = '{1, 0, 0,  1, 7, 0, 1, 1};
        tbl[19] = '{1, 0, 0,  1, 7, 0, 1, 1};
        tbl[20] = '{0, 0, 0,  1, 7, 0, 1, 0};
        tbl[21] = '{0, 0, 0,  1, 7, 0, 0, 0};
        tbl[22] = '{0, 0, 0,  1, 7, 0, 0, 0};
        tbl[23] = '{0, 0, 0,  1, 7, 0, 0, 0};
        tbl[24] = '{0, 0, 0,  0, 7, 0, 0, 0};
        tbl[25] = '{0, 0, 0,  0, 7, 0, 0, 0};
        tbl[26] = '{1, 0, 0,  1, 7, 0, 1, 1};
        tbl[27] = '{1, 0, 0,  1, 7, 0, 1, 1};
        tbl[28] = '{0, 0, 0,  1, 7, 0, 1, 1};
        tbl[29] = '{1, 0, 0,  1, 7, 0, 1, 0};
        tbl[30] = '{1, 0, 0,  1, 7, 0, 0, 0};
        tbl[31] = '{1, 0, 0,  1, 7, 0, 0, 0};
        tbl[32] = '{1, 0, 0,  1, 7, 0, 0, 0};
        tbl[33] = '{1, 0, 0,  1, 7, 0, 1, 1};

        sweep[0] = 2;
        sweep[1] = 3;
        sweep[2] = 5;
        sweep[3] = 255;

        rst      = 1'b1;
        en       = 1'b0;
        div_load = 1'b0;
        div_i    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_clk_div", int'(clk_div), 0);
        chk("reset_running", int'(running), 0);
        chk("reset_div_err", int'(div_err), 0);
        chk("reset_div_cur", int'(div_cur), 9);
        rst = 1'b0;

        for (int i = 0; i < 34; i++) begin
            do_cycle(tbl[i].en, tbl[i].ld, tbl[i].di, s1, s2);
            chk($sformatf("vec%0d_running", i), int'(running), int'(tbl[i].run));
            chk($sformatf("vec%0d_div_cur", i), int'(div_cur), tbl[i].cur);
            chk($sformatf("vec%0d_div_err", i), int'(div_err), int'(tbl[i].err));
            chk($sformatf("vec%0d_clk_hi1", i), int'(s1), int'(tbl[i].c1));
            chk($sformatf("vec%0d_clk_hi2", i), int'(s2), int'(tbl[i].c2));
        end

        // Ratio sweep with each load landing exactly on a wrap edge.
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            for (int k = 0; k < 600 && !found; k++) begin
                if (m_run && (m_p == m_n - 1)) found = 1'b1;
                else do_cycle(1'b1, 1'b0, 0, s1, s2);
            end
            chk($sformatf("sweep%0d_wrap_found", sweep[i]), int'(found), 1);
            do_cycle(1'b1, 1'b1, sweep[i], s1, s2);
        end
        for (int k = 0; k < 600; k++) do_cycle(1'b1, 1'b0, 0, s1, s2);

        e = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 24) == 0) e = !e;
            l = ($urandom_range(0, 7) == 0);
            r = int'($urandom_range(0, 19));
            if (r == 0)      d = int'($urandom_range(0, 1));
            else if (r == 1) d = 255;
            else             d = int'($urandom_range(2, 12));
            do_cycle(e, l, d, s1, s2);
        end

        // Asynchronous reset in the middle of a high phase with a non-default ratio.
        do_cycle(1'b1, 1'b1, 5, s1, s2);
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            if (m_run && (m_n == 5) && (m_p < 2)) found = 1'b1;
            else do_cycle(1'b1, 1'b0, 0, s1, s2);
        end
        chk("areset_setup_found", int'(found), 1);
        chk("areset_pre_clk_div", int'(clk_div), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("areset_clk_div", int'(clk_div), 0);
        chk("areset_running", int'(running), 0);
        chk("areset_div_cur", int'(div_cur), 9);
        chk("areset_div_err", int'(div_err), 0);
        model_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) do_cycle(1'b0, 1'b0, 0, s1, s2);
        for (int k = 0; k < 20; k++) do_cycle(1'b1, 1'b0, 0, s1, s2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
